vga_text_render: RTL and testbench

- Pixel-pipeline stage directly downstream of the VGA timing generator.
- Consumes its pixel coordinates (row/col), display-enable, h/v sync and once-per-frame pulse.
- Fetches character codes from the text buffer RAM and glyph rows from the font ROM. Drives 12-bit RGB with sync/de re-aligned to the pixel data.
- Implements an 80x30 character terminal (8x16 glyphs, 640x480) with a blinking block cursor.

---
 rtl/vga_text_render.sv | 170 +++++++++++++++++
 tb/tb_vga_text_render.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_render.sv
// vga_text_render: 80x30 text-mode pixel pipeline (8x16 glyphs, 640x480).
// Sits directly behind the VGA timing generator. It fetches a character code
// from the text RAM and a glyph row from the font ROM, then drives 12-bit RGB.
// Sync and display enable are delayed to stay aligned with the pixel data.
//
// Pipeline timing (input cycle = cycle 0):
//   edge 1 (S0): text_addr, glyph_row, bit_sel, cursor hit and de are registered.
//                text_data is valid during cycle 1.
//   edge 2 (S1): font_addr, inverse, bit_sel, cursor hit and de are registered.
//                font_data is valid during cycle 2.
//   edge 3 (S3): vga_rgb is registered, together with the 3rd sync/de stage.
// No handshake: the stage accepts one pixel per Clk, unconditionally.
module vga_text_render #(
    parameter int          COLS         = 80,
    parameter int          LINES        = 30,
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        de_in,
    input  logic        frame_in,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [11:0] vga_rgb,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        de_out
);

    // Character cell coordinates of the incoming pixel
    logic [6:0]  cell_x;
    logic [4:0]  cell_y;
    logic [11:0] addr_next;
    logic        hit_next;
    logic        cursor_in_range;

    // S0 registers
    logic [3:0]  glyph_row_s0;
    logic [2:0]  bit_sel_s0;
    logic        hit_s0;

    // S1 registers
    logic        inv_s1;
    logic [2:0]  bit_sel_s1;
    logic        hit_s1;

    // Sync / de shift registers; index 2 is the output stage
    logic [2:0]  hs_sr;
    logic [2:0]  vs_sr;
    logic [2:0]  de_sr;

    // S2 combinational pixel
    logic        pix_s2;

    // Cursor blink state
    logic        frame_q;
    logic        frame_edge;
    logic [7:0]  blink_cnt;
    logic        blink_on;

    assign cell_x = col[9:3];
    assign cell_y = row[8:4];

    // S0 address and cursor-hit computation from the raw coordinates
    always_comb begin
        addr_next       = 12'd0;
        cursor_in_range = (int'(cursor_x) < COLS) && (int'(cursor_y) < LINES);
        hit_next        = 1'b0;
        if (de_in) begin
            addr_next = 12'({7'd0, cell_y}) * 12'(COLS) + 12'({5'd0, cell_x});
            hit_next  = cursor_en && blink_on && cursor_in_range &&
                        (cell_x == cursor_x) && (cell_y == cursor_y);
        end
    end

    // S0: present the text RAM address and capture per-pixel fields
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            text_addr    <= 12'd0;
            glyph_row_s0 <= 4'd0;
            bit_sel_s0   <= 3'd0;
            hit_s0       <= 1'b0;
        end else begin
            text_addr    <= addr_next;
            glyph_row_s0 <= row[3:0];
            bit_sel_s0   <= col[2:0];
            hit_s0       <= hit_next;
        end
    end

    // S1: text_data has arrived; present the font ROM address
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            font_addr  <= 11'd0;
            inv_s1     <= 1'b0;
            bit_sel_s1 <= 3'd0;
            hit_s1     <= 1'b0;
        end else begin
            font_addr  <= {text_data[6:0], glyph_row_s0};
            inv_s1     <= text_data[7];
            bit_sel_s1 <= bit_sel_s0;
            hit_s1     <= hit_s0;
        end
    end

    // S2: select the glyph bit (bit7 is the leftmost pixel), apply inverse and cursor
    always_comb begin
        pix_s2 = font_data[3'd7 - bit_sel_s1] ^ inv_s1 ^ hit_s1;
    end

    // S3: colour the pixel, forcing black outside the active area
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            vga_rgb <= 12'h000;
        end else begin
            vga_rgb <= de_sr[1] ? (pix_s2 ? FG_RGB : BG_RGB) : 12'h000;
        end
    end

    // Delay sync and de by three cycles to match the pixel pipeline
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            hs_sr <= 3'b111;
            vs_sr <= 3'b111;
            de_sr <= 3'b000;
        end else begin
            hs_sr <= {hs_sr[1:0], h_sync_in};
            vs_sr <= {vs_sr[1:0], v_sync_in};
            de_sr <= {de_sr[1:0], de_in};
        end
    end

    assign h_sync_out = hs_sr[2];
    assign v_sync_out = vs_sr[2];
    assign de_out     = de_sr[2];

    // A long frame pulse counts only once, on its rising edge
    assign frame_edge = frame_in && !frame_q;

    // Cursor blink: toggle blink_on every BLINK_FRAMES frames
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            frame_q   <= 1'b0;
            blink_cnt <= 8'd0;
            blink_on  <= 1'b0;
        end else begin
            frame_q <= frame_in;
            if (frame_edge) begin
                if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= 8'd0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// Testbench for vga_text_render: table-driven pixel vectors plus directed
// sequences for the sync delay, the cursor blink and reset mid-line.
module tb_vga_text_render;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        rst = 1'b0;
    always #5 Clk = ~Clk;

    logic        h_sync_in, v_sync_in, de_in, frame_in;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        cursor_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] vga_rgb;
    logic        h_sync_out, v_sync_out, de_out;

    // Memory models: data follows the registered address, i.e. one cycle after the S0 input
    logic [7:0] text_mem [0:4095];
    logic [7:0] font_mem [0:2047];
    assign text_data = text_mem[text_addr];
    assign font_data = font_mem[font_addr];

    vga_text_render #(.BLINK_FRAMES(2)) dut (
        .Clk(Clk), .rst(rst),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in), .frame_in(frame_in),
        .row(row), .col(col),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .vga_rgb(vga_rgb), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .de_out(de_out)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        h_sync_in = 1'b1; v_sync_in = 1'b1; de_in = 1'b0; frame_in = 1'b0;
        row = 9'd0; col = 10'd0;
    endtask

    // Drive one pixel, then check its colour three cycles later
    task automatic check_pix(input logic [8:0] r, input logic [9:0] c,
                             input logic [11:0] exp, input string name);
        row = r; col = c; de_in = 1'b1;
        tick();
        de_in = 1'b0; row = 9'd0; col = 10'd0;
        tick();
        tick();
        check(name, {4'd0, vga_rgb}, {4'd0, exp});
    endtask

    task automatic frame_pulse(input int width);
        frame_in = 1'b1;
        repeat (width) tick();
        frame_in = 1'b0;
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        de;
        logic [7:0]  text;
        logic [7:0]  glyph;
        logic [11:0] exp_addr;
        logic [10:0] exp_faddr;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[20];

    initial begin
        for (int i = 0; i < 4096; i++) text_mem[i] = 8'h00;
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
        idle();
        cursor_en = 1'b0; cursor_x = 7'd0; cursor_y = 5'd0;

        // Origin pixel: code 'A', leftmost glyph bit set
        vecs[0] = '{9'd0,   10'd0,   1'b1, 8'h41, 8'h80, 12'd0,    11'h410, 12'hFFF};
        // Last visible pixel: line 29, column 79, glyph row 15, rightmost bit
        vecs[1] = '{9'd479, 10'd639, 1'b1, 8'h41, 8'h01, 12'd2399, 11'h41F, 12'hFFF};
        // Blanked, out-of-range row: address forced to 0, black regardless of ROM
        vecs[2] = '{9'd500, 10'd0,   1'b0, 8'h41, 8'hFF, 12'd0,    11'h414, 12'h000};
        // Line 2 glyph row 5, cell 12 bit 4
        vecs[3] = '{9'd37,  10'd100, 1'b1, 8'h7F, 8'h08, 12'd172,  11'h7F5, 12'hFFF};
        // Cell (1,1) glyph 0x81: edges lit, then the same with the inverse attribute
        for (int i = 0; i < 8; i++) begin
            vecs[4 + i]  = '{9'd16, 10'(8 + i), 1'b1, 8'h22, 8'h81, 12'd81, 11'h220,
                             (i == 0 || i == 7) ? 12'hFFF : 12'h000};
            vecs[12 + i] = '{9'd16, 10'(8 + i), 1'b1, 8'hA2, 8'h81, 12'd81, 11'h220,
                             (i == 0 || i == 7) ? 12'h000 : 12'hFFF};
        end

        // Reset state
        repeat (2) tick();
        check("rst_rgb",   {4'd0, vga_rgb},   16'h000);
        check("rst_hs",    {15'd0, h_sync_out}, 16'd1);
        check("rst_vs",    {15'd0, v_sync_out}, 16'd1);
        check("rst_de",    {15'd0, de_out},   16'd0);
        check("rst_taddr", {4'd0, text_addr}, 16'd0);
        check("rst_faddr", {5'd0, font_addr}, 16'd0);
        rst = 1'b1;
        tick();

        // Table-driven pixel vectors
        for (int v = 0; v < 20; v++) begin
            text_mem[vecs[v].exp_addr]  = vecs[v].text;
            font_mem[vecs[v].exp_faddr] = vecs[v].glyph;
            row = vecs[v].row; col = vecs[v].col; de_in = vecs[v].de;
            tick();
            check($sformatf("vec%0d_taddr", v), {4'd0, text_addr}, {4'd0, vecs[v].exp_addr});
            de_in = 1'b0; row = 9'd0; col = 10'd0;
            tick();
            check($sformatf("vec%0d_faddr", v), {5'd0, font_addr}, {5'd0, vecs[v].exp_faddr});
            tick();
            check($sformatf("vec%0d_rgb", v), {4'd0, vga_rgb}, {4'd0, vecs[v].exp_rgb});
            check($sformatf("vec%0d_de", v), {15'd0, de_out}, {15'd0, vecs[v].de});
        end

        // Random sync/de pattern: outputs equal inputs delayed by 3 cycles
        exp_q.delete();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 3) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("sync_delay", {13'd0, h_sync_out, v_sync_out, de_out}, {13'd0, e});
                if (!de_out) check("blank_rgb", {4'd0, vga_rgb}, 16'h000);
            end
            h_sync_in = 1'($urandom_range(0, 1));
            v_sync_in = 1'($urandom_range(0, 1));
            de_in     = 1'($urandom_range(0, 1));
            row       = 9'($urandom_range(0, 479));
            col       = 10'($urandom_range(0, 639));
            exp_q.push_back({h_sync_in, v_sync_in, de_in});
            tick();
        end
        idle();
        repeat (4) tick();

        // Cursor blink with BLINK_FRAMES=2, cursor at column 5, line 2
        cursor_en = 1'b1; cursor_x = 7'd5; cursor_y = 5'd2;
        check_pix(9'd32, 10'd40, 12'h000, "cur_blink0");
        frame_pulse(1);
        check_pix(9'd32, 10'd40, 12'h000, "cur_after_p1");
        frame_pulse(1);
        check_pix(9'd32, 10'd40, 12'hFFF, "cur_after_p2");
        check_pix(9'd47, 10'd47, 12'h000 ^ 12'hFFF, "cur_cell_corner");
        check_pix(9'd32, 10'd48, 12'h000, "cur_next_cell");
        frame_pulse(3);
        check_pix(9'd32, 10'd40, 12'hFFF, "cur_wide_pulse");
        frame_pulse(1);
        check_pix(9'd32, 10'd40, 12'h000, "cur_after_p4");
        frame_pulse(1);
        frame_pulse(1);
        check_pix(9'd32, 10'd40, 12'hFFF, "cur_after_p6");
        cursor_en = 1'b0;
        check_pix(9'd32, 10'd40, 12'h000, "cur_disabled");
        cursor_en = 1'b1;

        // Reset mid-line with blink_on=1 and a lit cursor pixel in flight
        h_sync_in = 1'b0; v_sync_in = 1'b0; de_in = 1'b1; row = 9'd32; col = 10'd40;
        repeat (4) tick();
        check("pre_rst_de",  {15'd0, de_out}, 16'd1);
        check("pre_rst_rgb", {4'd0, vga_rgb}, 16'hFFF);
        check("pre_rst_hs",  {15'd0, h_sync_out}, 16'd0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_rgb",   {4'd0, vga_rgb},   16'h000);
        check("mid_rst_hs",    {15'd0, h_sync_out}, 16'd1);
        check("mid_rst_vs",    {15'd0, v_sync_out}, 16'd1);
        check("mid_rst_de",    {15'd0, de_out},   16'd0);
        check("mid_rst_taddr", {4'd0, text_addr}, 16'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("refill1_de", {15'd0, de_out}, 16'd0);
        check("refill1_hs", {15'd0, h_sync_out}, 16'd1);
        tick();
        check("refill2_de", {15'd0, de_out}, 16'd0);
        tick();
        check("refill3_de",  {15'd0, de_out}, 16'd1);
        check("refill3_hs",  {15'd0, h_sync_out}, 16'd0);
        check("refill3_rgb", {4'd0, vga_rgb}, 16'h000);
        idle();
        repeat (3) tick();

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
